seq_booth_mult: RTL

//  Iterative signed multiplier using radix-2 Booth recoding, one recoding step per clock.
//  It is the sequential replacement for the combinational 4-bit signed multiplier in the

---
 rtl/mult_pkg.sv | 24 ++
 rtl/booth_step.sv | 32 +++
 rtl/seq_booth_mult.sv | 109 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared arithmetic-datapath constants: operand width default, multiplier FSM
// encodings and the radix-2 Booth recoding helper.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] BOOTH_NOP = 2'd0;
    localparam logic [1:0] BOOTH_ADD = 2'd1;
    localparam logic [1:0] BOOTH_SUB = 2'd2;

    // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out before it.
    function automatic logic [1:0] booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// followed by an arithmetic right shift of {A,Q,q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_1_in,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_1_out
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_in;
        case (booth_op(q_in[0], q_1_in))
            BOOTH_ADD: sum = acc_in + m;
            BOOTH_SUB: sum = acc_in - m;
            default:   sum = acc_in;
        endcase
        // A is one bit wider than the operands, so its MSB is the true sign to replicate.
        acc_out = {sum[WIDTH], sum[WIDTH:1]};
        q_out   = {sum[0], q_in[WIDTH-1:1]};
        q_1_out = q_in[0];
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Iterative signed multiplier: one radix-2 Booth step per clock, valid/ready on
// both sides, full-width 2*WIDTH signed product.
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]           state_q,   state_d;
    logic [WIDTH:0]       acc_q,     acc_d;
    logic [WIDTH:0]       m_q,       m_d;
    logic [WIDTH-1:0]     q_q,       q_d;
    logic                 q_1_q,     q_1_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       acc_step;
    logic [WIDTH-1:0]     q_step;
    logic                 q_1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc_q),
        .q_in    (q_q),
        .q_1_in  (q_1_q),
        .m       (m_q),
        .acc_out (acc_step),
        .q_out   (q_step),
        .q_1_out (q_1_step)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q_1_d     = q_1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = {a[WIDTH-1], a};
                    q_d     = b;
                    q_1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                q_d   = q_step;
                q_1_d = q_1_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Capture the product on the final step so it is valid on entry to DONE.
                if (cnt_q == LAST_CNT) begin
                    product_d = {acc_step[WIDTH-1:0], q_step};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q_1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q_1_q     <= q_1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = product_q;

endmodule
